// File: rtl/ram_pkg.sv
// Shared types, default widths and helpers for the byte-enable RAM with
// built-in clear sequencer.
package ram_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 9;
   localparam int DEPTH_DEF  = 512;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   function automatic int bytes_of(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/sync_ram_be_clr_if.sv
// Request/response bundle between a client (master) and the RAM (slave).
interface sync_ram_be_clr_if
   import ram_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);

   logic                          clr;
   logic                          req;
   logic                          we;
   logic [bytes_of(DATA_W)-1:0]   be;
   logic [ADDR_W-1:0]             addr;
   logic [DATA_W-1:0]             wdata;
   logic [DATA_W-1:0]             rdata;
   logic                          rvalid;
   logic                          ready;
   logic                          err;

   modport master (
      output clr, req, we, be, addr, wdata,
      input  rdata, rvalid, ready, err
   );

   modport slave (
      input  clr, req, we, be, addr, wdata,
      output rdata, rvalid, ready, err
   );

endinterface

// File: rtl/sync_ram_array.sv
// Plain word storage with per-byte write enables and a registered read port.
module sync_ram_array
   import ram_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ADDR_W-1:0]           i_addr,
   input  logic [DATA_W-1:0]           i_wdata,
   input  logic [bytes_of(DATA_W)-1:0] i_be,
   input  logic                        i_re,
   input  logic                        i_rzero,
   output logic [DATA_W-1:0]           o_rdata
);

   localparam int BYTES = bytes_of(DATA_W);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // NOTE: storage has no reset so it maps onto RAM macros; the clear sequencer initialises it.
   always_ff @(posedge clk) begin
      for (int b = 0; b < BYTES; b++) begin
         if (i_be[b]) begin
            // NOTE: sequential state always uses non-blocking assignment.
            r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
   end

   // Read register holds between reads; out-of-range reads load zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_addr];
      end else if (i_rzero) begin
         r_rdata <= '0;
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_ram_be_clr.sv
// Clocked single-port RAM with byte enables, range checking and a clear
// sequencer that fills every word with INIT_VAL after reset or on clr.
module sync_ram_be_clr
   import ram_pkg::*;
#(
   parameter int                DATA_W   = DATA_W_DEF,
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                DEPTH    = DEPTH_DEF,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   sync_ram_be_clr_if.slave bus
);

   localparam int                BYTES     = bytes_of(DATA_W);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] w_ptr_nxt;
   logic              r_rvalid;
   logic              r_err;

   logic              w_in_range;
   logic              w_rd_fire;
   logic              w_err;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;
   logic [BYTES-1:0]  w_mem_be;
   logic              w_mem_re;
   logic              w_mem_rzero;
   logic [DATA_W-1:0] w_rdata;

   assign w_in_range = ({1'b0, bus.addr} < DEPTH_EXT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_CLEAR;
         r_ptr    <= '0;
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_ptr    <= w_ptr_nxt;
         r_rvalid <= w_rd_fire;
         r_err    <= w_err;
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_mem_addr  = bus.addr;
      w_mem_wdata = bus.wdata;
      w_mem_be    = '0;
      w_mem_re    = 1'b0;
      w_mem_rzero = 1'b0;
      w_rd_fire   = 1'b0;
      w_err       = 1'b0;

      case (r_state)
         ST_CLEAR: begin
            w_mem_addr  = r_ptr;
            w_mem_wdata = INIT_VAL;
            w_mem_be    = '1;
            if (bus.clr) begin
               w_ptr_nxt = '0;
            end else if (r_ptr == LAST_ADDR) begin
               w_state_nxt = ST_IDLE;
               w_ptr_nxt   = '0;
            end else begin
               w_ptr_nxt = r_ptr + ADDR_W'(1);
            end
         end

         ST_IDLE: begin
            if (bus.req) begin
               w_rd_fire = !bus.we;
               w_err     = !w_in_range;
               if (w_in_range) begin
                  w_mem_be = bus.we ? bus.be : '0;
                  w_mem_re = !bus.we;
               end else begin
                  w_mem_rzero = !bus.we;
               end
            end
            // The same-cycle request above is still serviced before clearing.
            if (bus.clr) begin
               w_state_nxt = ST_CLEAR;
               w_ptr_nxt   = '0;
            end
         end

         default: w_state_nxt = ST_CLEAR;
      endcase
   end

   sync_ram_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .i_addr  (w_mem_addr),
      .i_wdata (w_mem_wdata),
      .i_be    (w_mem_be),
      .i_re    (w_mem_re),
      .i_rzero (w_mem_rzero),
      .o_rdata (w_rdata)
   );

   assign bus.rdata  = w_rdata;
   assign bus.rvalid = r_rvalid;
   assign bus.err    = r_err;
   assign bus.ready  = (r_state == ST_IDLE);

endmodule
